// File: rtl/can_bit_destuffer.sv
// can_bit_destuffer: removes CAN stuff bits, flags stuff errors, tracks bus idle and error recovery.
// Define CAN_DESTUFF_STATS_EN to add saturating stuff_count / stuff_err_count outputs.
module can_bit_destuffer #(
    parameter int STUFF_LEN = 5,
    parameter int IDLE_LEN  = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_bit,
    input  logic        sample_valid,
    input  logic        stuff_enable,
    input  logic        error_in,
    output logic        rx_bit,
    output logic        rx_clk,
    output logic        stuff_error,
    output logic        in_error,
    output logic        bus_idle
`ifdef CAN_DESTUFF_STATS_EN
    ,
    output logic [15:0] stuff_count,
    output logic [7:0]  stuff_err_count
`endif
);
    localparam int RW = $clog2(IDLE_LEN + 1);
    typedef enum logic [1:0] {BUS_IDLE, STUFFING, NO_STUFF, ERROR} state_t;
    state_t        state, state_n;
    logic [RW-1:0] run, run_n, run_inc, run_rec;
    logic          last, last_n, pend, pend_n, rx_bit_n, rx_clk_n, serr_n;
    assign run_inc  = (&run) ? run : run + RW'(1);
    // consecutive-recessive count shared by NO_STUFF and ERROR
    assign run_rec  = !sample_bit ? '0 : (last ? run_inc : RW'(1));
    assign in_error = state == ERROR;
    assign bus_idle = state == BUS_IDLE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= BUS_IDLE;
            run         <= '0;
            last        <= 1'b1;
            pend        <= 1'b0;
            rx_bit      <= 1'b1;
            rx_clk      <= 1'b0;
            stuff_error <= 1'b0;
        end else begin
            state       <= state_n;
            run         <= run_n;
            last        <= last_n;
            pend        <= pend_n;
            rx_bit      <= rx_bit_n;
            rx_clk      <= rx_clk_n;
            stuff_error <= serr_n;
        end
    end
    always_comb begin
        state_n  = state;
        run_n    = run;
        last_n   = last;
        pend_n   = pend;
        rx_bit_n = rx_bit;
        rx_clk_n = 1'b0;
        serr_n   = 1'b0;
        if (error_in) begin
            state_n = ERROR;
            run_n   = '0;
            pend_n  = 1'b0;
        end else if (sample_valid) begin
            // a pending stuff bit is checked even after stuff_enable falls
            if (state == STUFFING && pend) begin
                pend_n = 1'b0;
                if (sample_bit != last) begin
                    run_n  = RW'(1);
                    last_n = sample_bit;
                end else begin
                    serr_n  = 1'b1;
                    state_n = ERROR;
                    run_n   = '0;
                end
            end else if (state == BUS_IDLE || (state == STUFFING && stuff_enable)) begin
                rx_clk_n = 1'b1;
                rx_bit_n = sample_bit;
                last_n   = sample_bit;
                run_n    = (sample_bit == last) ? run_inc : RW'(1);
                pend_n   = (state == STUFFING) && (run_n == RW'(STUFF_LEN));
                if (state == BUS_IDLE) begin
                    run_n   = sample_bit ? '0 : RW'(1);
                    state_n = sample_bit ? BUS_IDLE : STUFFING;
                end
            end else begin
                if (state != ERROR) begin
                    rx_clk_n = 1'b1;
                    rx_bit_n = sample_bit;
                end
                last_n  = sample_bit;
                run_n   = (run_rec == RW'(IDLE_LEN)) ? '0 : run_rec;
                state_n = (run_rec == RW'(IDLE_LEN)) ? BUS_IDLE : ((state == ERROR) ? ERROR : NO_STUFF);
            end
        end
    end
`ifdef CAN_DESTUFF_STATS_EN
    logic drop;
    assign drop = sample_valid && !error_in && state == STUFFING && pend && sample_bit != last;
    always_ff @(posedge clock) begin
        if (reset) begin
            stuff_count     <= '0;
            stuff_err_count <= '0;
        end else begin
            if (drop && !(&stuff_count)) stuff_count <= stuff_count + 16'd1;
            if (serr_n && !(&stuff_err_count)) stuff_err_count <= stuff_err_count + 8'd1;
        end
    end
`endif
endmodule
